serial_adder: RTL and testbench

Bit-serial ripple adder built around the team's single-bit `full_adder` cell. It accepts two WIDTH-bit operands plus a carry-in over a valid/ready handshake. It then feeds the cell one bit pair per clock, LSB first, with the carry held in a flip-flop between cycles. The block is the sequencing stage directly upstream of the cell: it supplies A/B/C each cycle and consumes Carry/Sum.

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/serial_adder_full_adder.sv | 19 +
 rtl/serial_adder.sv | 116 +++++++++++
 tb/tb_serial_adder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder: FSM state encoding and
//   the default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder
//   Single-bit full adder cell used by the serial adder for all addition.
//   Ports:
//     A, B  : operand bits
//     C     : carry in
//     Sum   : A ^ B ^ C
//     Carry : majority(A, B, C)
module full_adder (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic Carry,
  output logic Sum
);

  assign Sum   = A ^ B ^ C;
  assign Carry = (A & B) | (A & C) | (B & C);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial ripple adder. Accepts two WIDTH-bit operands and a carry-in
//   over a valid/ready handshake, then adds one bit pair per clock (LSB
//   first) through a single full_adder cell, holding the carry in a flop.
//   Ports:
//     clk, rst_n          : clock, async active-low reset
//     in_valid / in_ready : operand handshake (a, b, cin)
//     out_valid/out_ready : result handshake (sum, cout, ovf)
//     sum                 : a + b + cin mod 2^WIDTH
//     cout                : unsigned carry-out
//     ovf                 : signed overflow (carry into MSB ^ carry out of MSB)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready for operands, result registers hold the last result
//   ST_RUN  | one bit pair per cycle through the cell, WIDTH cycles
//   ST_DONE | result valid and stable until out_ready
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cout_q, ovf_q;
  logic             fa_carry, fa_sum;
  logic             accept, last_bit;

  full_adder u_fa (
    .A     (a_sh[0]),
    .B     (b_sh[0]),
    .C     (carry),
    .Carry (fa_carry),
    .Sum   (fa_sum)
  );

  assign accept   = (state_q == ST_IDLE) && in_valid;
  assign last_bit = (state_q == ST_RUN) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last_bit)  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // sum_sh is a working register; the visible result lives in sum_q so it
  // stays put during the next RUN until that operation completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state_q == ST_RUN) begin
      sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      carry  <= fa_carry;
      cnt    <= cnt + 1'b1;
      if (last_bit) begin
        sum_q  <= {fa_sum, sum_sh[WIDTH-1:1]};
        cout_q <= fa_carry;
        // carry currently holds the carry into the MSB
        ovf_q  <= carry ^ fa_carry;
      end
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for out_valid, sampling 1 time unit after each rising edge.
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                       input logic ic, input logic [7:0] es, input logic ec, input logic eo);
    int n;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = ia; b = ib; cin = ic; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = ~ia; b = ~ib; cin = ~ic;
    wait_done(n);
    check({tag, "_latency"}, 32'(n), 32'd8);
    check({tag, "_sum"},  32'(sum),  32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"},  32'(ovf),  32'(eo));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_release"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("t1_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    do_op("t2_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op("t3_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    do_op("t3_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    do_op("t4_ff_ff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // backpressure, ignored in_valid, simultaneous out_ready/in_valid
    @(negedge clk);
    a = 8'h30; b = 8'h12; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 8'h01; b = 8'h01;
    check("t5_run_in_ready", 32'(in_ready), 32'd0);
    wait_done(n);
    check("t5_latency", 32'(n), 32'd8);
    check("t5_sum", 32'(sum), 32'h42);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("t5_hold_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("t5_hold_sum%0d", i),   32'(sum),       32'h42);
      check($sformatf("t5_hold_rdy%0d", i),   32'(in_ready),  32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t5_xfer_valid", 32'(out_valid), 32'd0);
    check("t5_xfer_ready", 32'(in_ready),  32'd1);
    check("t5_retain_sum", 32'(sum),       32'h42);
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("t5_accepted", 32'(in_ready), 32'd0);
    check("t5_retain_run", 32'(sum), 32'h42);
    wait_done(n);
    check("t5_next_latency", 32'(n), 32'd8);
    check("t5_next_sum", 32'(sum), 32'h02);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // reset in the 4th RUN cycle
    a = 8'h55; b = 8'hAA; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_sum",   32'(sum),       32'd0);
    check("t6_rst_ready", 32'(in_ready),  32'd1);
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) n++;
    end
    check("t6_no_pulse", 32'(n), 32'd0);
    do_op("t6_55_aa_c1", 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
